// File: rtl/usb_packet_pkg.sv
// rtl/usb_packet_pkg.sv - shared USB packet constants, TX state encoding and CRC16 byte update
//
// Purpose : PID values, CRC16 constants, the DATA TX builder state type and a
//           bytewise CRC16 step shared by the CRC unit and the TX builder.
// Ports   : none (package).
package usb_packet_pkg;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;

  // Polynomial 0x8005 as written in the USB spec; the register shifts
  // LSB-first, so the update uses the bit-reversed form.
  localparam logic [15:0] CRC16_POLY           = 16'h8005;
  localparam logic [15:0] CRC16_POLY_REFLECTED = 16'hA001;
  localparam logic [15:0] CRC16_INIT           = 16'hFFFF;
  // Remainder left by a good packet including its CRC (MSB-first form).
  localparam logic [15:0] CRC16_RESIDUAL       = 16'h800D;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEND_PID    = 3'd1,
    SEND_DATA   = 3'd2,
    SEND_CRC_LO = 3'd3,
    SEND_CRC_HI = 3'd4,
    WAIT_RESULT = 3'd5,
    FINISH      = 3'd6
  } txState_t;

  // One byte through the LSB-first CRC16 register (uncomplemented).
  function automatic logic [15:0] crc16Byte(input logic [15:0] crcIn,
                                            input logic [7:0]  dataIn);
    logic [15:0] c;
    c = crcIn;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ dataIn[i]) c = (c >> 1) ^ CRC16_POLY_REFLECTED;
      else                  c = c >> 1;
    end
    return c;
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// rtl/usb_crc16.sv - bytewise USB CRC16 accumulator, one byte per cycle
//
// Purpose : running CRC16 register; init_i presets it, valid_i folds in data_i.
// Ports   : clk_i, rst_i (sync, active-high), init_i, valid_i, data_i[7:0],
//           crc_o[15:0] raw (uncomplemented) register value.
module usb_crc16
  import usb_packet_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i || init_i) begin
      crc_o <= CRC16_INIT;
    end else if (valid_i) begin
      crc_o <= crc16Byte(crc_o, data_i);
    end
  end

endmodule

// File: rtl/usb_data_tx_builder.sv
// rtl/usb_data_tx_builder.sv - builds one USB DATA packet (PID, payload, CRC16) from a transactional FIFO
//
// Purpose : on start, sends {~pid,pid}, up to MAX_PACKET_SIZE FIFO bytes and the
//           CRC16, then waits for the host handshake and commits (ack) or rolls
//           back (timeout) the FIFO pop transaction.
// Ports   : clk_i, rst_i (sync, active-high); start_i, pid_i[3:0] request;
//           fifoDataAvailable_i, fifoIsLast_i, fifoData_i[7:0], fifoPopData_o,
//           fifoPopTransDone_o, fifoPopTransSuccess_o FIFO side;
//           txDataValid_o, txData_o[7:0], txIsLast_o, txAcceptData_i TX stream;
//           ackReceived_i, ackTimeout_i handshake; busy_o, done_o, success_o status.
module usb_data_tx_builder
  import usb_packet_pkg::*;
#(
  parameter int MAX_PACKET_SIZE = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [3:0] pid_i,
  input  logic       fifoDataAvailable_i,
  input  logic       fifoIsLast_i,
  input  logic [7:0] fifoData_i,
  output logic       fifoPopData_o,
  output logic       fifoPopTransDone_o,
  output logic       fifoPopTransSuccess_o,
  output logic       txDataValid_o,
  output logic [7:0] txData_o,
  output logic       txIsLast_o,
  input  logic       txAcceptData_i,
  input  logic       ackReceived_i,
  input  logic       ackTimeout_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       success_o
);

  localparam int COUNT_W = $clog2(MAX_PACKET_SIZE + 1);
  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(MAX_PACKET_SIZE);

  txState_t           state;
  logic [3:0]         pidReg;
  logic [COUNT_W-1:0] byteCount;
  logic               ackReg;
  logic [15:0]        crcReg;
  logic               startAccept;
  logic               dataFire;

  assign startAccept = (state == IDLE) && start_i;
  assign dataFire    = (state == SEND_DATA) && fifoDataAvailable_i && txAcceptData_i;

  usb_crc16 crcUnit (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .init_i  (startAccept),
    .valid_i (dataFire),
    .data_i  (fifoData_i),
    .crc_o   (crcReg)
  );

  // All outputs decode from state, so they read as zero the cycle after reset.
  always_comb begin
    txDataValid_o = 1'b0;
    txData_o      = 8'h00;
    txIsLast_o    = 1'b0;
    case (state)
      SEND_PID: begin
        txDataValid_o = 1'b1;
        txData_o      = {~pidReg, pidReg};
      end
      SEND_DATA: begin
        txDataValid_o = fifoDataAvailable_i;
        txData_o      = fifoData_i;
      end
      SEND_CRC_LO: begin
        txDataValid_o = 1'b1;
        txData_o      = ~crcReg[7:0];
      end
      SEND_CRC_HI: begin
        txDataValid_o = 1'b1;
        txData_o      = ~crcReg[15:8];
        txIsLast_o    = 1'b1;
      end
      default: ;
    endcase
  end

  assign fifoPopData_o         = dataFire;
  assign fifoPopTransDone_o    = (state == FINISH);
  assign fifoPopTransSuccess_o = (state == FINISH) && ackReg;
  assign busy_o                = (state != IDLE);
  assign done_o                = (state == FINISH);
  assign success_o             = (state == FINISH) && ackReg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      pidReg    <= 4'h0;
      byteCount <= '0;
      ackReg    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            pidReg    <= pid_i;
            byteCount <= '0;
            state     <= SEND_PID;
          end
        end
        SEND_PID: begin
          // An empty FIFO at PID time makes this a zero-length packet.
          if (txAcceptData_i) state <= fifoDataAvailable_i ? SEND_DATA : SEND_CRC_LO;
        end
        SEND_DATA: begin
          if (dataFire) begin
            byteCount <= byteCount + 1'b1;
            if (fifoIsLast_i || (byteCount + 1'b1 == MAX_COUNT)) state <= SEND_CRC_LO;
          end else if (!fifoDataAvailable_i && (byteCount != '0)) begin
            state <= SEND_CRC_LO;
          end
        end
        SEND_CRC_LO: begin
          if (txAcceptData_i) state <= SEND_CRC_HI;
        end
        SEND_CRC_HI: begin
          if (txAcceptData_i) state <= WAIT_RESULT;
        end
        WAIT_RESULT: begin
          // Ack takes priority when it coincides with the timeout.
          if (ackReceived_i) begin
            ackReg <= 1'b1;
            state  <= FINISH;
          end else if (ackTimeout_i) begin
            ackReg <= 1'b0;
            state  <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_data_tx_builder.sv
// tb/tb_usb_data_tx_builder.sv - scoreboard bench for usb_data_tx_builder
`timescale 1ns/1ps
module tb_usb_data_tx_builder;
  localparam int MAXP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, ackRx, ackTo, txAccept;
  logic [3:0] pid;
  logic       fifoAvail, fifoLast;
  logic [7:0] fifoData;
  logic       fifoPop, transDone, transSuccess, txValid, txLast, busy, done, success;
  logic [7:0] txData;

  usb_data_tx_builder #(.MAX_PACKET_SIZE(MAXP)) dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .start_i               (start),
    .pid_i                 (pid),
    .fifoDataAvailable_i   (fifoAvail),
    .fifoIsLast_i          (fifoLast),
    .fifoData_i            (fifoData),
    .fifoPopData_o         (fifoPop),
    .fifoPopTransDone_o    (transDone),
    .fifoPopTransSuccess_o (transSuccess),
    .txDataValid_o         (txValid),
    .txData_o              (txData),
    .txIsLast_o            (txLast),
    .txAcceptData_i        (txAccept),
    .ackReceived_i         (ackRx),
    .ackTimeout_i          (ackTo),
    .busy_o                (busy),
    .done_o                (done),
    .success_o             (success)
  );

  // Transactional FIFO responder: every written byte is committed.
  logic [7:0] fifoMem [0:4095];
  int wrPtr, rdPtr, basePtr;
  assign fifoAvail = (rdPtr < wrPtr);
  assign fifoLast  = (rdPtr == wrPtr - 1);
  assign fifoData  = fifoMem[rdPtr[11:0]];

  always @(posedge clk) begin
    if (rst) begin
      rdPtr   <= 0;
      basePtr <= 0;
    end else begin
      if (fifoPop) rdPtr <= rdPtr + 1;
      if (transDone) begin
        if (transSuccess) basePtr <= rdPtr;
        else              rdPtr   <= basePtr;
      end
    end
  end

  typedef struct { bit success; int pops; } result_t;
  logic [8:0] expBytes[$];
  result_t    expRes[$];
  logic [7:0] refQ[$];
  int tests = 0;
  int fails = 0;
  int popCount = 0;
  bit lastSeen, doneSeen;
  bit holdValid = 1'b0;
  logic [8:0] holdByte;
  logic [8:0] expByte;
  result_t    expR;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic failNow(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // USB CRC16 from first principles: MSB-first shifter over the bit stream
  // sent LSB-first, then reflected and complemented.
  function automatic logic [15:0] usbCrc(input logic [7:0] d[$]);
    logic [15:0] c;
    logic [15:0] r;
    logic fb;
    c = 16'hFFFF;
    foreach (d[k]) begin
      for (int i = 0; i < 8; i++) begin
        fb = c[15] ^ d[k][i];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int i = 0; i < 16; i++) r[i] = c[15-i];
    return ~r;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a byte or a result.
  always @(negedge clk) begin
    if (rst) begin
      holdValid = 1'b0;
    end else begin
      if (holdValid) begin
        check("stall_valid_held", txValid, 1);
        check("stall_data_stable", {txLast, txData}, holdByte);
      end
      holdValid = txValid && !txAccept;
      holdByte  = {txLast, txData};
      if (txValid && txAccept) begin
        if (expBytes.size() == 0) failNow("unexpected_tx_byte");
        else begin
          expByte = expBytes.pop_front();
          check("tx_byte", {txLast, txData}, expByte);
        end
        if (txLast) lastSeen = 1'b1;
      end
      if (fifoPop) popCount++;
      if (done || transDone) begin
        check("done_vs_trans_done", transDone, done);
        check("no_pop_with_trans_done", fifoPop, 0);
        if (expRes.size() == 0) failNow("unexpected_done");
        else begin
          expR = expRes.pop_front();
          check("success", success, expR.success);
          check("trans_success", transSuccess, expR.success);
          check("pop_count", popCount, expR.pops);
        end
        popCount = 0;
        doneSeen = 1'b1;
      end
    end
  end

  task automatic pushByte(input logic [7:0] b);
    fifoMem[wrPtr] = b;
    wrPtr++;
    refQ.push_back(b);
  endtask

  task automatic checkIdle(input string name);
    check(name, {txValid, txLast, fifoPop, transDone, transSuccess, busy, done, success, txData}, 0);
  endtask

  // kind: 0 ack, 1 timeout, 2 both in the same cycle
  task automatic sendPacket(input logic [3:0] pidV, input int kind, input bit randAcc, input bit noise);
    logic [7:0] pl[$];
    logic [15:0] c;
    result_t r;
    int n, cyc;
    n = (refQ.size() < MAXP) ? refQ.size() : MAXP;
    for (int i = 0; i < n; i++) pl.push_back(refQ[i]);
    c = usbCrc(pl);
    expBytes.push_back({1'b0, ~pidV, pidV});
    foreach (pl[i]) expBytes.push_back({1'b0, pl[i]});
    expBytes.push_back({1'b0, c[7:0]});
    expBytes.push_back({1'b1, c[15:8]});
    r.success = (kind != 1);
    r.pops    = n;
    expRes.push_back(r);
    lastSeen = 1'b0;
    doneSeen = 1'b0;
    @(posedge clk); #1 start = 1'b1; pid = pidV;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (!lastSeen && cyc < 500) begin
      txAccept = randAcc ? 1'($urandom_range(0, 1)) : 1'b1;
      if (noise) begin
        ackRx = ($urandom_range(0, 3) == 0);
        ackTo = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 3) == 0);
        pid   = 4'($urandom_range(0, 15));
      end
      @(posedge clk); #1;
      cyc++;
    end
    ackRx = 1'b0; ackTo = 1'b0; start = 1'b0; txAccept = 1'b1;
    if (!lastSeen) failNow("last_byte_timeout");
    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    ackRx = (kind != 1);
    ackTo = (kind != 0);
    @(posedge clk); #1 ackRx = 1'b0; ackTo = 1'b0;
    cyc = 0;
    while (!doneSeen && cyc < 20) begin @(posedge clk); #1; cyc++; end
    if (!doneSeen) failNow("done_timeout");
    if (kind != 1) repeat (n) refQ.delete(0);
  endtask

  task automatic resetMidPacket();
    logic [7:0] pl[$];
    logic [15:0] c;
    result_t r;
    int cyc;
    for (int i = 0; i < 6; i++) pushByte(8'($urandom_range(0, 255)));
    for (int i = 0; i < 6; i++) pl.push_back(refQ[i]);
    c = usbCrc(pl);
    expBytes.push_back(9'h0C3);
    foreach (pl[i]) expBytes.push_back({1'b0, pl[i]});
    expBytes.push_back({1'b0, c[7:0]});
    expBytes.push_back({1'b1, c[15:8]});
    r.success = 1'b1;
    r.pops    = 6;
    expRes.push_back(r);
    @(posedge clk); #1 start = 1'b1; pid = 4'h3;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (popCount < 2 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    if (popCount < 2) failNow("reset_test_pop_timeout");
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    expBytes.delete();
    expRes.delete();
    refQ.delete();
    wrPtr = 0;
    popCount = 0;
    @(negedge clk);
    checkIdle("reset_mid_packet_outputs");
    repeat (4) begin
      @(negedge clk);
      check("no_trans_done_after_reset", {transDone, done}, 0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pid = 4'h0; ackRx = 1'b0; ackTo = 1'b0; txAccept = 1'b1;
    wrPtr = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkIdle("reset_outputs");

    // Zero-length DATA1: 4B 00 00, no pops.
    sendPacket(4'hB, 0, 1'b0, 1'b0);

    // Normal DATA0 packet: timeout rolls back, resend then commits.
    for (int i = 0; i < 4; i++) pushByte(8'(i));
    sendPacket(4'h3, 1, 1'b0, 1'b0);
    sendPacket(4'h3, 0, 1'b0, 1'b0);

    // Size cap: 20 committed bytes leave as 8 + 8 + 4.
    for (int i = 0; i < 20; i++) pushByte(8'($urandom_range(0, 255)));
    repeat (3) sendPacket(4'hB, 0, 1'b0, 1'b0);

    // Backpressure.
    for (int i = 0; i < 6; i++) pushByte(8'($urandom_range(0, 255)));
    sendPacket(4'h3, 0, 1'b1, 1'b0);

    // Ack and timeout together, with stray control inputs while sending.
    for (int i = 0; i < 3; i++) pushByte(8'($urandom_range(0, 255)));
    sendPacket(4'hB, 2, 1'b1, 1'b1);

    resetMidPacket();

    repeat (30) begin
      repeat ($urandom_range(0, 12)) pushByte(8'($urandom_range(0, 255)));
      sendPacket($urandom_range(0, 1) ? 4'hB : 4'h3, int'($urandom_range(0, 2)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

endmodule
